// File: rtl/im_loader.sv
// im_loader: writer side of the byte-addressed instruction store.
// A valid/ready byte stream carries a 16-bit big-endian word count followed by
// the program image. The image is written from byte address 0, and the CPU is
// held while the load runs. A combinational fetch port returns a big-endian
// 32-bit word that starts at any byte address. The upper bytes wrap around the
// end of the store.
module im_loader #(
    parameter int ADDR_W    = 13,
    parameter int MAX_WORDS = 2048
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       o_inst,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so that 4*MAX_WORDS (a full store) still fits in the counter.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_len_hi;
    logic [ADDR_W-1:0] r_wptr;
    logic [CNT_W-1:0]  r_bytes_left;
    logic              r_done;
    logic              r_err;

    logic [7:0]        r_mem [DEPTH];

    logic              w_xfer;
    logic              w_start_ok;
    logic [15:0]       w_len_full;
    logic              w_len_bad;
    logic [CNT_W-1:0]  w_len_bytes;
    logic              w_last_byte;
    logic              w_mem_we;

    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [ADDR_W-1:0] w_addr3;

    assign w_xfer      = i_in_valid && o_in_ready;
    assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_full  = {r_len_hi, i_in_data};
    assign w_len_bad   = (w_len_full == 16'd0) || (w_len_full > 16'(MAX_WORDS));
    assign w_len_bytes = {w_len_full[CNT_W-3:0], 2'b00};
    assign w_last_byte = (r_bytes_left == CNT_W'(1));
    assign w_mem_we    = w_xfer && (r_state == S_DATA) && !i_rst;

    assign w_addr1 = i_addr + ADDR_W'(1);
    assign w_addr2 = i_addr + ADDR_W'(2);
    assign w_addr3 = i_addr + ADDR_W'(3);

    assign o_inst     = {r_mem[i_addr], r_mem[w_addr1], r_mem[w_addr2], r_mem[w_addr3]};
    assign o_cpu_hold = o_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

    // State register: reset always returns the loader to IDLE, even in the middle of a stream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs: the loader accepts bytes and holds the CPU only while the header or data is streaming.
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid) begin
                    w_state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid) begin
                    w_state_next = w_len_bad ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid && w_last_byte) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_state_next = S_LEN_HI;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Load bookkeeping: capture the header, count down the image bytes, and keep the sticky done/err flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len_hi     <= 8'd0;
            r_wptr       <= '0;
            r_bytes_left <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            case (r_state)
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= i_in_data;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_wptr <= '0;
                        if (w_len_bad) begin
                            r_bytes_left <= '0;
                            r_err        <= 1'b1;
                            r_done       <= 1'b0;
                        end else begin
                            r_bytes_left <= w_len_bytes;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wptr       <= r_wptr + ADDR_W'(1);
                        r_bytes_left <= r_bytes_left - CNT_W'(1);
                        if (w_last_byte) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte store write port: no reset, so a partial or rejected load leaves the earlier contents in place.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_wptr] <= i_in_data;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized scoreboard bench for im_loader.
// The stimulus side streams images and pushes the expected load completions,
// status snapshots and fetch words into queues. It keeps a byte-array model of
// the store. A monitor process running on the falling clock edge pops the
// queues and compares the entries whenever the DUT ends a load or a check is
// requested.
module tb_im_loader;

   localparam int ADDR_W = 13;
   localparam int DEPTH  = 8192;
   localparam int MAXW   = 2048;

   typedef logic [7:0] byteQ_t[$];
   typedef struct {
      int   xfers;
      logic done;
      logic err;
   } compl_t;

   logic              clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic              i_in_valid = 1'b0;
   logic [7:0]        i_in_data = 8'd0;
   logic              o_in_ready;
   logic [ADDR_W-1:0] i_addr = '0;
   logic [31:0]       o_inst;
   logic              o_busy;
   logic              o_cpu_hold;
   logic              o_done;
   logic              o_err;

   int testsRun = 0;
   int failCount = 0;

   compl_t      complQ[$];
   logic [4:0]  statusQ[$];
   logic [31:0] fetchQ[$];

   logic fetchReq = 1'b0;
   logic statusReq = 1'b0;
   logic monEnable = 1'b0;
   logic prevBusy = 1'b0;
   int   xferCount = 0;

   logic [7:0] modelMem [DEPTH];
   bit         modelValid [DEPTH];

   im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .o_in_ready (o_in_ready),
      .i_addr     (i_addr),
      .o_inst     (o_inst),
      .o_busy     (o_busy),
      .o_cpu_hold (o_cpu_hold),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the actual value differs from the expected one.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] st(input logic busy, input logic ready, input logic done, input logic err);
      return {busy, busy, ready, done, err};
   endfunction

   // Monitor: counts byte transfers, checks each load completion (the falling edge of busy) and serves the requested snapshots.
   always @(negedge clk) begin : monitor
      compl_t c;
      if (monEnable) begin
         if (i_in_valid && o_in_ready && !i_rst) xferCount++;
         if (prevBusy && !o_busy) begin
            if (complQ.size() == 0) begin
               checkOutput("unexpected load end", 32'(xferCount), 32'hFFFF_FFFF);
            end else begin
               c = complQ.pop_front();
               checkOutput("transfers per load", 32'(xferCount), 32'(c.xfers));
               checkOutput("done at load end", 32'(o_done), 32'(c.done));
               checkOutput("err at load end", 32'(o_err), 32'(c.err));
            end
            xferCount = 0;
         end
         if (statusReq) begin
            if (statusQ.size() == 0) checkOutput("status underflow", 32'd0, 32'd1);
            else checkOutput("status {busy,hold,ready,done,err}",
                             32'({o_busy, o_cpu_hold, o_in_ready, o_done, o_err}),
                             32'(statusQ.pop_front()));
         end
         if (fetchReq) begin
            if (fetchQ.size() == 0) checkOutput("fetch underflow", 32'd0, 32'd1);
            else checkOutput("fetch inst", o_inst, fetchQ.pop_front());
         end
      end
      prevBusy = o_busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startLoad();
      i_in_valid = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic requestStatus(input logic [4:0] exp);
      i_in_valid = 1'b0;
      statusQ.push_back(exp);
      statusReq = 1'b1;
      tick();
      statusReq = 1'b0;
   endtask

   task automatic requestFetch(input int addr);
      logic [31:0] exp;
      exp = {modelMem[addr % DEPTH], modelMem[(addr + 1) % DEPTH],
             modelMem[(addr + 2) % DEPTH], modelMem[(addr + 3) % DEPTH]};
      i_in_valid = 1'b0;
      i_addr = 13'(addr);
      fetchQ.push_back(exp);
      fetchReq = 1'b1;
      tick();
      fetchReq = 1'b0;
   endtask

   // Fetches a few random addresses whose four bytes have all been written by some earlier load.
   task automatic fetchRandom(input int n);
      for (int i = 0; i < n; i++) begin
         for (int tries = 0; tries < 200; tries++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            if (modelValid[a] && modelValid[(a + 1) % DEPTH] &&
                modelValid[(a + 2) % DEPTH] && modelValid[(a + 3) % DEPTH]) begin
               requestFetch(a);
               break;
            end
         end
      end
   endtask

   // mode 0: valid held high, 1: valid toggling, 2: random valid. noise injects start pulses mid-stream.
   task automatic applyStimulus(input byteQ_t q, input int mode, input bit noise);
      bit tog;
      tog = 1'b1;
      foreach (q[k]) begin
         int  guard;
         bit  sent;
         guard = 0;
         sent = 1'b0;
         while (!sent) begin
            logic v;
            case (mode)
               0: v = 1'b1;
               1: begin v = tog; tog = !tog; end
               default: v = 1'($urandom_range(0, 1));
            endcase
            i_in_valid = v;
            i_in_data = v ? q[k] : 8'($urandom);
            i_start = noise && ($urandom_range(0, 3) == 0);
            sent = v && o_in_ready;
            tick();
            guard++;
            if (!sent && guard > 64) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL stream stall: byte %0d accepted=0, required=1 within 64 cycles", k);
               i_in_valid = 1'b0;
               i_start = 1'b0;
               return;
            end
         end
      end
      i_in_valid = 1'b0;
      i_start = 1'b0;
   endtask

   // Loads a full image. With checks set, the status is also checked right after start and just before the final byte.
   task automatic doLoad(input byteQ_t img, input int mode, input bit noise, input bit checks);
      int     words;
      byteQ_t q;
      byteQ_t last;
      compl_t c;
      words = img.size() / 4;
      q.push_back(8'(words >> 8));
      q.push_back(8'(words));
      foreach (img[k]) begin
         q.push_back(img[k]);
         modelMem[k] = img[k];
         modelValid[k] = 1'b1;
      end
      c.xfers = 2 + 4 * words;
      c.done = 1'b1;
      c.err = 1'b0;
      complQ.push_back(c);
      startLoad();
      if (checks) begin
         requestStatus(st(1, 1, 0, 0));
         last.push_back(q.pop_back());
         applyStimulus(q, mode, noise);
         requestStatus(st(1, 1, 0, 0));
         applyStimulus(last, mode, noise);
      end else begin
         applyStimulus(q, mode, noise);
      end
   endtask

   task automatic doBadLoad(input logic [7:0] hi, input logic [7:0] lo);
      byteQ_t q;
      compl_t c;
      q.push_back(hi);
      q.push_back(lo);
      c.xfers = 2;
      c.done = 1'b0;
      c.err = 1'b1;
      complQ.push_back(c);
      startLoad();
      applyStimulus(q, 0, 1'b0);
   endtask

   function automatic byteQ_t randImage(input int words);
      byteQ_t q;
      for (int i = 0; i < 4 * words; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Main stimulus sequence.
   initial begin
      byteQ_t img;
      byteQ_t part;
      compl_t c;

      for (int i = 0; i < DEPTH; i++) modelValid[i] = 1'b0;

      repeat (3) tick();
      i_rst = 1'b0;
      monEnable = 1'b1;
      requestStatus(st(0, 0, 0, 0));

      // Basic two-word image with valid held high.
      img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      doLoad(img, 0, 1'b0, 1'b0);
      requestStatus(st(0, 0, 1, 0));
      requestFetch(0);
      requestFetch(4);

      // Same image with toggling valid. Also checks that start in DONE clears done.
      img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      doLoad(img, 1, 1'b0, 1'b1);
      requestFetch(0);
      requestFetch(4);
      requestFetch(2);

      // Smallest legal image.
      doLoad(randImage(1), 2, 1'b1, 1'b0);
      requestFetch(0);

      // Random images with random valid and start pulses injected mid-stream.
      for (int n = 0; n < 6; n++) begin
         doLoad(randImage($urandom_range(1, 24)), $urandom_range(0, 2), 1'b1, 1'b0);
         requestStatus(st(0, 0, 1, 0));
         fetchRandom(3);
      end

      // Full-size image. Checks the fetch wrap at the top of the store.
      img = randImage(MAXW);
      img[0] = 8'h11;
      img[1] = 8'h22;
      img[2] = 8'h33;
      img[DEPTH - 1] = 8'hAA;
      doLoad(img, 0, 1'b0, 1'b0);
      requestFetch(DEPTH - 1);
      requestFetch(DEPTH - 2);
      requestFetch(DEPTH - 3);
      fetchRandom(3);

      // Rejected headers leave the memory untouched. Bytes offered in DONE are ignored.
      doBadLoad(8'h00, 8'h00);
      requestStatus(st(0, 0, 0, 1));
      i_in_valid = 1'b1;
      i_in_data = 8'h5A;
      repeat (3) tick();
      requestStatus(st(0, 0, 0, 1));
      doBadLoad(8'h08, 8'h01);
      requestStatus(st(0, 0, 0, 1));
      requestFetch(0);
      requestFetch(DEPTH - 1);
      fetchRandom(3);

      // Reset after 5 of 8 data bytes. Bytes 0-4 stay, then a fresh load works.
      part = '{8'h00, 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      for (int k = 0; k < 5; k++) modelMem[k] = part[k + 2];
      c.xfers = 7;
      c.done = 1'b0;
      c.err = 1'b0;
      complQ.push_back(c);
      startLoad();
      applyStimulus(part, 2, 1'b0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      requestStatus(st(0, 0, 0, 0));
      requestFetch(0);
      requestFetch(1);
      doLoad(randImage(2), 2, 1'b1, 1'b1);
      requestFetch(0);
      requestFetch(4);

      repeat (4) tick();
      checkOutput("pending load ends", 32'(complQ.size()), 32'd0);
      checkOutput("pending status checks", 32'(statusQ.size()), 32'd0);
      checkOutput("pending fetch checks", 32'(fetchQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
